mux_oht_pipe: RTL
=================

# mux_oht_pipe

Pipelined one-hot multiplexer tree with valid/ready flow control. Selects one element of a `WIDTH`-entry data array with a one-hot vector, reducing in `SPLIT`-way levels, with an optional register after each tree level chosen by a bitmask. It is the registered, back-pressurable successor to the combinational one-hot mux, for wide arbiter and crossbar data paths that do not close timing in one cycle.

## Interface

Parameters:
- `DAT_T`, `logic [8-1:0]`, data element type
- `WIDTH`, 32, number of array entries (≥1)
- `SPLIT`, 2, tree radix (≥2)
- `PIPE`, `'1`, bitmask of length `LEVELS`; bit `l`=1 registers the output of tree level `l` (level 0 is nearest the inputs)
- `IMPLEMENTATION`, 0, selects the per-node `mux_oht_base` variant

Ports:
- `clk`, in, 1, clock
- `rst`, in, 1, reset, asynchronous, active-high
- `s_vld`, in, 1, input transfer valid
- `s_rdy`, out, 1, input transfer ready
- `oht`, in, `WIDTH`, one-hot select, sampled on input transfer
- `ary`, in, `WIDTH` x `DAT_T`, data array, sampled on input transfer
- `m_vld`, out, 1, output transfer valid
- `m_rdy`, in, 1, output transfer ready
- `m_hit`, out, 1, OR reduction of the sampled `oht`
- `m_dat`, out, `DAT_T`, selected element; `'0` when `m_hit`=0

## Operation

- `LEVELS = clogbase(WIDTH, SPLIT)`, `POWER = SPLIT**LEVELS`. If `WIDTH != POWER`, `oht` is zero-extended to `POWER` and the padded array entries are driven `'0`.
- Each level `l` holds `POWER/SPLIT**(l+1)` nodes. Each node takes `SPLIT` (hit, dat) pairs. It outputs hit = OR of the hits and dat = OR of (dat_i AND hit_i).
- A registered level `l` has one valid bit `v[l]` plus hit/dat registers for all of its nodes.
- Stage enable: `en[l] = !v[l] || rdy_next[l]`. `rdy_next` is `m_rdy` for the last registered level, or the enable of the next registered level.
- `s_rdy` is the enable of the first registered level, or `m_rdy` if `PIPE`=0.
- A register loads when its enable is high. The loaded valid equals the upstream valid, so bubbles collapse.
- This is a full-throughput pipeline: one transfer per cycle is sustained while `m_rdy`=1. There is no skid buffer, and `s_rdy` depends combinationally on `m_rdy` through the enable chain.
- When `PIPE`=0 the block is purely combinational: `m_vld=s_vld`, `s_rdy=m_rdy`.
- Non-one-hot `oht`: the result is the OR of all selected entries, and `m_hit`=1 if any bit is set. There is no error flag. Verification treats multi-hot as legal with OR semantics.
- Data is never reordered, dropped or duplicated. Each accepted input produces exactly one output transfer.

## Timing

- Latency from an accepted input to `m_vld` is `$countones(PIPE)` cycles when there is no back-pressure.
- Output stability: while `m_vld`=1 and `m_rdy`=0, `m_vld`, `m_hit` and `m_dat` hold stable. The upstream may change `oht`/`ary` freely while `s_rdy`=0.
- Reset (asynchronous assert, synchronous release by the system) sets every `v[l]` to 0 and every hit/dat register to `'0`.
  - Outputs during reset: `m_vld`=0, `m_hit`=0, `m_dat`=`'0`.
  - `s_rdy` equals 1 during reset when `PIPE`≠0.
- Reset mid-stream discards all in-flight transfers. The first cycle after release accepts new input.
- Full pipeline with `m_rdy`=0: `s_rdy`=0.
  - When `m_rdy` rises, `s_rdy` rises in the same cycle, and all stages shift together.
- Simultaneous accept and emit on a full pipeline is a pass-through with no lost cycle.

## Structure

- Package `mux_pkg` holds:
  - `clogbase` function (integer ceil-log, arbitrary base)
  - helper `pipe_cnt(PIPE)` for the latency constant
- Sub-module: `mux_oht_base`, the single `SPLIT`-way node, reused from the existing library and instantiated per node via `generate`.
- Expected size is 150–300 lines.

## Test plan

- `WIDTH`=32, `SPLIT`=2, `PIPE`=5'b11111, `m_rdy`=1. Input `oht`=1<<k, `ary[i]`=i for k=0..31 back-to-back → `m_dat`=k with `m_hit`=1, 5 cycles later, one per cycle.
- `WIDTH`=5, `SPLIT`=2, `PIPE`=3'b010. Input `oht`=5'b10000, `ary[4]`=8'hA5 → `m_dat`=8'hA5 after 1 cycle. Input `oht`=0 → `m_hit`=0, `m_dat`=8'h00.
- `WIDTH`=9, `SPLIT`=3, `PIPE`=2'b11. Hold `m_rdy`=0 after 2 inputs → `s_rdy`=0 and outputs stable. Release `m_rdy` → both inputs delivered in order, with `s_rdy`=1 in the same cycle.
- Random `s_vld`/`m_rdy` (50%) for 10k transfers against a scoreboard model → no loss, reordering or duplication; stability holds under stall.
- Assert `rst` with 3 transfers in flight → `m_vld`=0, `m_hit`=0, `m_dat`=0 immediately (asynchronous). After release, the next input emerges with the nominal latency.
- `PIPE`=0 and `oht`=32'h0000_0011 with `ary[0]`=8'h0F, `ary[4]`=8'hF0 → `m_dat`=8'hFF combinationally, `m_vld` follows `s_vld`.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared helpers for the one-hot mux tree: integer ceil-log in an arbitrary base
// and the pipeline latency derived from the level register mask.
package mux_pkg;

    function automatic int unsigned clogbase(input int unsigned n, input int unsigned base);
        int unsigned r;
        longint unsigned p;
        r = 0;
        p = 1;
        while (p < longint'(n)) begin
            p = p * longint'(base);
            r = r + 1;
        end
        return r;
    endfunction

    // A single-entry array still needs one node level to produce an output.
    function automatic int unsigned tree_levels(input int unsigned n, input int unsigned base);
        int unsigned l;
        l = clogbase(n, base);
        return (l == 0) ? 1 : l;
    endfunction

    function automatic int unsigned pipe_cnt(input logic [31:0] pipe);
        return $countones(pipe);
    endfunction

endpackage

// File: rtl/mux_oht_base.sv
// Single SPLIT-way one-hot mux node: hit is the OR of the hits, data is the OR of
// every input whose hit is set.
module mux_oht_base #(
    parameter type         DAT_T          = logic [8-1:0],
    parameter int unsigned SPLIT          = 2,
    parameter int unsigned IMPLEMENTATION = 0
) (
    input  logic [SPLIT-1:0] hit_i,
    input  DAT_T [SPLIT-1:0] dat_i,
    output logic             hit_o,
    output DAT_T             dat_o
);

    localparam int unsigned DW = $bits(DAT_T);

    assign hit_o = |hit_i;

    if (IMPLEMENTATION == 0) begin : g_cond
        always_comb begin
            dat_o = '0;
            for (int i = 0; i < int'(SPLIT); i++) begin
                if (hit_i[i]) begin
                    dat_o = dat_o | dat_i[i];
                end
            end
        end
    end else begin : g_mask
        // Pure AND-OR form, friendlier to some synthesis flows than the conditional.
        always_comb begin
            dat_o = '0;
            for (int i = 0; i < int'(SPLIT); i++) begin
                dat_o = dat_o | (dat_i[i] & {DW{hit_i[i]}});
            end
        end
    end

endmodule

// File: rtl/mux_oht_pipe.sv
// Pipelined one-hot mux tree with valid/ready flow control. Each tree level may be
// registered; the ready chain runs combinationally back from m_rdy (no skid buffer).
module mux_oht_pipe
    import mux_pkg::*;
#(
    parameter type                                  DAT_T          = logic [8-1:0],
    parameter int unsigned                          WIDTH          = 32,
    parameter int unsigned                          SPLIT          = 2,
    parameter logic [tree_levels(WIDTH, SPLIT)-1:0] PIPE           = '1,
    parameter int unsigned                          IMPLEMENTATION = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_vld,
    output logic             s_rdy,
    input  logic [WIDTH-1:0] oht,
    input  DAT_T [WIDTH-1:0] ary,
    output logic             m_vld,
    input  logic             m_rdy,
    output logic             m_hit,
    output DAT_T             m_dat
);

    localparam int unsigned LEVELS = tree_levels(WIDTH, SPLIT);
    localparam int unsigned POWER  = SPLIT ** LEVELS;
    localparam int unsigned DW     = $bits(DAT_T);
    localparam int unsigned PAD_W  = POWER * DW;

    // Zero-extend select and data up to a full SPLIT-ary tree.
    logic [POWER-1:0] pad_hit;
    DAT_T [POWER-1:0] pad_dat;

    assign pad_hit = POWER'(oht);
    assign pad_dat = PAD_W'(ary);

    for (genvar l = 0; l < int'(LEVELS); l++) begin : g_lvl
        localparam int unsigned NODES = POWER / (SPLIT ** (l + 1));

        logic [NODES*SPLIT-1:0] in_hit;
        DAT_T [NODES*SPLIT-1:0] in_dat;
        logic                   in_vld;
        logic [NODES-1:0]       nd_hit;
        DAT_T [NODES-1:0]       nd_dat;
        logic [NODES-1:0]       out_hit;
        DAT_T [NODES-1:0]       out_dat;
        logic                   out_vld;
        logic                   rdy_nxt;
        logic                   rdy_up;

        if (l == 0) begin : g_src
            assign in_hit = pad_hit;
            assign in_dat = pad_dat;
            assign in_vld = s_vld;
        end else begin : g_src
            assign in_hit = g_lvl[l-1].out_hit;
            assign in_dat = g_lvl[l-1].out_dat;
            assign in_vld = g_lvl[l-1].out_vld;
        end

        if (l == int'(LEVELS) - 1) begin : g_snk
            assign rdy_nxt = m_rdy;
        end else begin : g_snk
            assign rdy_nxt = g_lvl[l+1].rdy_up;
        end

        for (genvar n = 0; n < int'(NODES); n++) begin : g_node
            mux_oht_base #(
                .DAT_T          (DAT_T),
                .SPLIT          (SPLIT),
                .IMPLEMENTATION (IMPLEMENTATION)
            ) u_node (
                .hit_i (in_hit[n*SPLIT +: SPLIT]),
                .dat_i (in_dat[n*SPLIT +: SPLIT]),
                .hit_o (nd_hit[n]),
                .dat_o (nd_dat[n])
            );
        end

        if (PIPE[l]) begin : g_reg
            logic             vld_q, vld_d;
            logic [NODES-1:0] hit_q, hit_d;
            DAT_T [NODES-1:0] dat_q, dat_d;
            logic             en;

            // Load whenever empty or the downstream takes the current word.
            always_comb begin
                en    = !vld_q || rdy_nxt;
                vld_d = vld_q;
                hit_d = hit_q;
                dat_d = dat_q;
                if (en) begin
                    vld_d = in_vld;
                    hit_d = nd_hit;
                    dat_d = nd_dat;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    hit_q <= '0;
                    dat_q <= '0;
                end else begin
                    vld_q <= vld_d;
                    hit_q <= hit_d;
                    dat_q <= dat_d;
                end
            end

            assign out_vld = vld_q;
            assign out_hit = hit_q;
            assign out_dat = dat_q;
            assign rdy_up  = en;
        end else begin : g_comb
            assign out_vld = in_vld;
            assign out_hit = nd_hit;
            assign out_dat = nd_dat;
            assign rdy_up  = rdy_nxt;
        end
    end

    assign s_rdy = g_lvl[0].rdy_up;
    assign m_vld = g_lvl[LEVELS-1].out_vld;
    assign m_hit = g_lvl[LEVELS-1].out_hit[0];
    assign m_dat = g_lvl[LEVELS-1].out_dat[0];

endmodule
